seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Decodes a time-multiplexed, active-low 7-segment display bus back into per-digit BCD values. This is the inverse of the digit-to-segment encoder.
- Monitors anode selects and segment lines, accepts a pattern only after it has been stable for a programmable number of cycles, and stores one BCD value plus decimal point per digit.
- Used as an on-chip display monitor and as a self-check scoreboard for the button press counter display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits and width of the anode select bus.
- STABLE_CYCLES, 4, consecutive identical samples required before commit. Legal range 1..255.

Ports:
- clk  input  1  system clock; all inputs synchronous to it (any synchroniser sits upstream).
- rst_n  input  1  reset, asynchronous, active-low.
- anode_n  input  NUM_DIGITS  digit select, active-low, one-hot-low when legal.
- segments_n  input  8  segment lines, active-low; bit7 = dp, bits6:0 = g..a.
- digits  output  4*NUM_DIGITS  committed BCD values; digit i occupies bits 4i+3:4i; 4'hF = blank/unknown.
- digit_valid  output  NUM_DIGITS  1 = digit i holds a decoded numeral.
- dp  output  NUM_DIGITS  committed decimal point per digit, active-high.
- update  output  1  one-cycle pulse when a commit changes any stored value of that digit.
- pattern_err  output  1  one-cycle pulse when an illegal pattern reaches the stable count.
- sel_err  output  1  high in every cycle where anode_n has two or more low bits.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - digits = all 4'hF, digit_valid = 0, dp = 0.
  - update, pattern_err, sel_err = 0.
  - Run counter = 0; last-sample registers cleared to invalid.
  - Reset dominates any simultaneous commit.
- Select decode (combinational):
  - Exactly one low bit in anode_n: select valid, index i.
  - All bits high: idle.
  - Two or more low bits: sel_err = 1 (combinational, not registered).
- Pattern decode on segments_n[6:0]:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F → blank.
  - Any other value → illegal.
  - dp_in = ~segments_n[7].
- Stability tracking on each rising edge:
  - If select is not valid: run_cnt ← 0 and last_sel is marked invalid.
  - Else if (i, segments_n) equals the registered last sample: run_cnt ← min(run_cnt+1, STABLE_CYCLES).
  - Else: run_cnt ← 1 and the last sample is loaded.
  - A full 8-bit segments_n compare is used, so a dp change restarts the run.
- Commit:
  - Occurs on the edge where run_cnt transitions to STABLE_CYCLES, i.e. the STABLE_CYCLES-th consecutive identical sampled edge. With STABLE_CYCLES = 1, every new sample commits on its first edge.
  - Outputs are registered and visible immediately after that edge.
  - Only one commit per run. Saturation at STABLE_CYCLES blocks re-commit until the run breaks.
- Commit actions:
  - Legal numeral: digits[i] ← value, digit_valid[i] ← 1, dp[i] ← dp_in.
  - Blank: digits[i] ← 4'hF, digit_valid[i] ← 0, dp[i] ← dp_in.
  - Illegal: pattern_err pulses for one cycle; digit i storage is unchanged.
  - update pulses in the commit cycle only if digits[i], digit_valid[i] or dp[i] actually changed.
- Other digits are never modified by a commit to digit i.
- Switching to a different select, or to a different pattern on the same select, restarts the run at 1. Glitches shorter than STABLE_CYCLES are never committed.
- No internal scan-rate assumption; any dwell of at least STABLE_CYCLES per digit is decoded.

Test Plan:
- Reset: assert rst_n=0 mid-run with run_cnt=3 → digits=16'hFFFF, digit_valid=0, dp=0, no update; after release a fresh 4-cycle run is needed to commit.
- Basic commit: anode_n=4'b1110, segments_n=8'hA4 held 14 cycles → digits[3:0]=2 and digit_valid[0]=1 after edge 4; update high only on edge 4; no further pulses.
- Glitch filter: digit 1 gets segments_n=8'h99 for 3 cycles, then 8'h92 for 4 → digits[7:4]=5; value 4 never appears; exactly one update.
- Illegal pattern: anode_n=4'b1101, segments_n=8'hFE held 4 cycles → pattern_err pulses once on edge 4; digit 1 unchanged, update=0.
- Multi-select: anode_n=4'b1010 for 6 cycles → sel_err=1 every cycle, no commit, run_cnt=0; a following legal run needs the full 4 cycles.
- Round-robin scan:
  - Stimulus: digits 0..3 driven 5 cycles each with 8'hF9, 8'hA4, 8'h30 (dp on), 8'h99.
  - Required: digits=16'h4321, digit_valid=4'hF, dp=4'b0100.
  - Then blank digit 3 with 8'hFF → digit_valid=4'h7 and digits[15:12]=4'hF.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Display-bus bundle for the segment scan decoder: the sniffed anode/segment
// lines plus the committed digit view and the error/update strobes.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [7:0]              segments_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    update;
  logic                    pattern_err;
  logic                    sel_err;

  modport master (
    output anode_n, segments_n,
    input  digits, digit_valid, dp, update, pattern_err, sel_err
  );

  modport slave (
    input  anode_n, segments_n,
    output digits, digit_valid, dp, update, pattern_err, sel_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus,
// committing a (digit, pattern) sample only after it has been stable long enough.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_decoder_if.slave bus
);
  localparam int                    IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            STABLE  = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   sel_act;
  logic                    sel_none;
  logic                    sel_multi;
  logic                    sel_valid;
  logic [IW-1:0]           sel_idx;

  logic [3:0]              pat_val;
  logic                    pat_legal;
  logic                    pat_blank;

  logic [7:0]              run_q, run_d;
  logic                    last_vld_q, last_vld_d;
  logic [IW-1:0]           last_idx_q, last_idx_d;
  logic [7:0]              last_seg_q, last_seg_d;
  logic                    same_sample;
  logic                    commit;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    update_q, update_d;
  logic                    perr_q, perr_d;

  logic [3:0]              new_dig;
  logic                    new_val;
  logic                    new_dp;

  // One-hot-low select: clearing the lowest set bit leaves zero only for one-hot.
  assign sel_act   = ~bus.anode_n;
  assign sel_none  = (sel_act == '0);
  assign sel_multi = ((sel_act & (sel_act - SEL_ONE)) != '0);
  assign sel_valid = !sel_none && !sel_multi;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_act[i]) begin
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    pat_val   = 4'hF;
    pat_legal = 1'b0;
    pat_blank = 1'b0;
    case (bus.segments_n[6:0])
      7'h40: begin pat_val = 4'd0; pat_legal = 1'b1; end
      7'h79: begin pat_val = 4'd1; pat_legal = 1'b1; end
      7'h24: begin pat_val = 4'd2; pat_legal = 1'b1; end
      7'h30: begin pat_val = 4'd3; pat_legal = 1'b1; end
      7'h19: begin pat_val = 4'd4; pat_legal = 1'b1; end
      7'h12: begin pat_val = 4'd5; pat_legal = 1'b1; end
      7'h02: begin pat_val = 4'd6; pat_legal = 1'b1; end
      7'h78: begin pat_val = 4'd7; pat_legal = 1'b1; end
      7'h00: begin pat_val = 4'd8; pat_legal = 1'b1; end
      7'h10: begin pat_val = 4'd9; pat_legal = 1'b1; end
      7'h7F: pat_blank = 1'b1;
      default: ;
    endcase
  end

  // Full 8-bit compare so a dp toggle alone restarts the run.
  assign same_sample = last_vld_q && (sel_idx == last_idx_q) &&
                       (bus.segments_n == last_seg_q);

  always_comb begin
    run_d      = run_q;
    last_vld_d = last_vld_q;
    last_idx_d = last_idx_q;
    last_seg_d = last_seg_q;
    commit     = 1'b0;
    if (!sel_valid) begin
      run_d      = 8'd0;
      last_vld_d = 1'b0;
    end else if (same_sample) begin
      // Saturated runs hold at STABLE and never commit again.
      if (run_q < STABLE) begin
        run_d  = run_q + 8'd1;
        commit = (run_d == STABLE);
      end
    end else begin
      run_d      = 8'd1;
      last_vld_d = 1'b1;
      last_idx_d = sel_idx;
      last_seg_d = bus.segments_n;
      commit     = (STABLE == 8'd1);
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    update_d = 1'b0;
    perr_d   = 1'b0;
    new_dig  = pat_legal ? pat_val : 4'hF;
    new_val  = pat_legal;
    new_dp   = ~bus.segments_n[7];
    if (commit) begin
      if (pat_legal || pat_blank) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IW'(i) == sel_idx) begin
            if ((digits_q[4*i +: 4] != new_dig) || (valid_q[i] != new_val) ||
                (dp_q[i] != new_dp)) begin
              update_d = 1'b1;
            end
            digits_d[4*i +: 4] = new_dig;
            valid_d[i]         = new_val;
            dp_d[i]            = new_dp;
          end
        end
      end else begin
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 8'd0;
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
      last_seg_q <= 8'hFF;
      digits_q   <= '1;
      valid_q    <= '0;
      dp_q       <= '0;
      update_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      run_q      <= run_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
      last_seg_q <= last_seg_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      dp_q       <= dp_d;
      update_q   <= update_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.dp          = dp_q;
  assign bus.update      = update_q;
  assign bus.pattern_err = perr_q;
  assign bus.sel_err     = rst_n & sel_multi;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a per-cycle reference model feeds an
// expectation queue that a monitor drains after each clock edge.
module tb_seg_scan_decoder;
  localparam int N = 4;
  localparam int S = 4;

  logic clk;
  logic rst_n;

  seg_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  dp;
    logic        upd;
    logic        perr;
    logic        serr;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;
  bit saw4 = 0;

  // reference model state
  int          m_run = 0;
  bit          m_lv = 0;
  int          m_lidx = 0;
  logic [7:0]  m_lseg = 8'hFF;
  logic [15:0] m_dig = 16'hFFFF;
  logic [3:0]  m_val = 4'h0;
  logic [3:0]  m_dp = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [6:0] p);
    case (p)
      7'h40: return 0;
      7'h79: return 1;
      7'h24: return 2;
      7'h30: return 3;
      7'h19: return 4;
      7'h12: return 5;
      7'h02: return 6;
      7'h78: return 7;
      7'h00: return 8;
      7'h10: return 9;
      7'h7F: return 15;
      default: return -1;
    endcase
  endfunction

  task automatic model_step(input bit r, input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    int nlow = 0;
    int idx = 0;
    bit cm = 0;
    int v;
    logic [3:0] nd;
    e.upd = 0;
    e.perr = 0;
    for (int i = 0; i < N; i++) begin
      if (a[i] == 1'b0) begin
        nlow++;
        idx = i;
      end
    end
    if (!r) begin
      m_run = 0; m_lv = 0; m_lseg = 8'hFF;
      m_dig = 16'hFFFF; m_val = 0; m_dp = 0;
    end else begin
      if (nlow != 1) begin
        m_run = 0; m_lv = 0;
      end else if (m_lv && idx == m_lidx && s == m_lseg) begin
        if (m_run < S) begin
          m_run++;
          cm = (m_run == S);
        end
      end else begin
        m_run = 1; m_lv = 1; m_lidx = idx; m_lseg = s;
        cm = (S == 1);
      end
      if (cm) begin
        v = dec(s[6:0]);
        if (v < 0) begin
          e.perr = 1;
        end else begin
          nd = 4'(v);
          if (m_dig[idx*4 +: 4] != nd || m_val[idx] != (v != 15) || m_dp[idx] != ~s[7])
            e.upd = 1;
          m_dig[idx*4 +: 4] = nd;
          m_val[idx] = (v != 15);
          m_dp[idx] = ~s[7];
        end
      end
    end
    e.dig = m_dig;
    e.val = m_val;
    e.dp = m_dp;
    e.serr = r && (nlow >= 2);
    q.push_back(e);
  endtask

  // Drive on the falling edge; returns after the monitor has checked the rising edge.
  task automatic cyc(input bit r, input logic [3:0] a, input logic [7:0] s);
    @(negedge clk);
    rst_n = r;
    bus.anode_n = a;
    bus.segments_n = s;
    model_step(r, a, s);
    if (!r) begin
      #1;
      check("async_rst_digits", 32'(bus.digits), 32'hFFFF);
      check("async_rst_valid", 32'(bus.digit_valid), 32'h0);
      check("async_rst_dp", 32'(bus.dp), 32'h0);
      check("async_rst_update", 32'(bus.update), 32'h0);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, a, s);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("digits", 32'(bus.digits), 32'(e.dig));
        check("digit_valid", 32'(bus.digit_valid), 32'(e.val));
        check("dp", 32'(bus.dp), 32'(e.dp));
        check("update", 32'(bus.update), 32'(e.upd));
        check("pattern_err", 32'(bus.pattern_err), 32'(e.perr));
        check("sel_err", 32'(bus.sel_err), 32'(e.serr));
      end
      if (bus.update === 1'b1) upd_cnt++;
      if (bus.pattern_err === 1'b1) perr_cnt++;
      if (bus.sel_err === 1'b1) serr_cnt++;
      if (bus.digits[7:4] === 4'h4) saw4 = 1;
    end
  end

  initial begin : stim
    int u0, p0, s0;
    rst_n = 1'b0;
    bus.anode_n = 4'hF;
    bus.segments_n = 8'hFF;
    cyc(1'b0, 4'hF, 8'hFF);
    cyc(1'b0, 4'hF, 8'hFF);
    hold(4'hF, 8'hFF, 2);
    check("reset_digits", 32'(bus.digits), 32'hFFFF);
    check("reset_valid", 32'(bus.digit_valid), 32'h0);
    check("reset_sel_err", 32'(bus.sel_err), 32'h0);

    // basic commit on digit 0
    u0 = upd_cnt;
    hold(4'b1110, 8'hA4, 3);
    check("basic_pre_commit", 32'(bus.digits[3:0]), 32'hF);
    hold(4'b1110, 8'hA4, 1);
    check("basic_digit0", 32'(bus.digits[3:0]), 32'h2);
    check("basic_valid0", 32'(bus.digit_valid[0]), 32'h1);
    hold(4'b1110, 8'hA4, 10);
    check("basic_update_count", 32'(upd_cnt - u0), 32'd1);

    // glitch filter on digit 1
    u0 = upd_cnt;
    saw4 = 0;
    hold(4'b1101, 8'h99, 3);
    hold(4'b1101, 8'h92, 4);
    check("glitch_digit1", 32'(bus.digits[7:4]), 32'h5);
    check("glitch_no_four", 32'(saw4), 32'h0);
    check("glitch_update_count", 32'(upd_cnt - u0), 32'd1);

    // illegal pattern on digit 1
    u0 = upd_cnt;
    p0 = perr_cnt;
    hold(4'b1101, 8'hFE, 4);
    check("illegal_perr_count", 32'(perr_cnt - p0), 32'd1);
    check("illegal_digit1", 32'(bus.digits[7:4]), 32'h5);
    check("illegal_update_count", 32'(upd_cnt - u0), 32'd0);

    // multi-select, then a full-length legal run on digit 2
    s0 = serr_cnt;
    hold(4'b1010, 8'hB0, 6);
    check("multi_sel_err_count", 32'(serr_cnt - s0), 32'd6);
    hold(4'b1011, 8'hB0, 3);
    check("multi_after_3", 32'(bus.digit_valid[2]), 32'h0);
    hold(4'b1011, 8'hB0, 1);
    check("multi_after_4", 32'(bus.digit_valid[2]), 32'h1);
    check("multi_digit2", 32'(bus.digits[11:8]), 32'h3);

    // reset in the middle of a run of 3
    hold(4'b0111, 8'h99, 3);
    cyc(1'b0, 4'b0111, 8'h99);
    cyc(1'b0, 4'b0111, 8'h99);
    hold(4'b0111, 8'h99, 3);
    check("rst_mid_after_3", 32'(bus.digit_valid[3]), 32'h0);
    hold(4'b0111, 8'h99, 1);
    check("rst_mid_after_4", 32'(bus.digit_valid[3]), 32'h1);
    check("rst_mid_digit3", 32'(bus.digits[15:12]), 32'h4);

    // round-robin scan of all four digits
    hold(4'b1110, 8'hF9, 5);
    hold(4'b1101, 8'hA4, 5);
    hold(4'b1011, 8'h30, 5);
    hold(4'b0111, 8'h99, 5);
    check("rr_digits", 32'(bus.digits), 32'h4321);
    check("rr_valid", 32'(bus.digit_valid), 32'hF);
    check("rr_dp", 32'(bus.dp), 32'h4);
    hold(4'b0111, 8'hFF, 5);
    check("blank_valid", 32'(bus.digit_valid), 32'h7);
    check("blank_digit3", 32'(bus.digits[15:12]), 32'hF);
    check("blank_keep_low", 32'(bus.digits[11:0]), 32'h321);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
